// File: rtl/processor_pkg.sv
// Shared encodings for the multi-cycle processor: opcodes, ALU ops,
// exception status codes and the five-state instruction sequencer.
package processor_pkg;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_J     = 5'b00001;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_JAL   = 5'b00011;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_SETX  = 5'b10101;
  localparam logic [4:0] OP_BEX   = 5'b10110;

  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_SUB = 5'b00001;
  localparam logic [4:0] ALU_AND = 5'b00010;
  localparam logic [4:0] ALU_OR  = 5'b00011;
  localparam logic [4:0] ALU_SLL = 5'b00100;
  localparam logic [4:0] ALU_SRA = 5'b00101;
  localparam logic [4:0] ALU_MUL = 5'b00110;
  localparam logic [4:0] ALU_DIV = 5'b00111;

  localparam logic [31:0] EXC_ADD  = 32'd1;
  localparam logic [31:0] EXC_ADDI = 32'd2;
  localparam logic [31:0] EXC_SUB  = 32'd3;
  localparam logic [31:0] EXC_MUL  = 32'd4;
  localparam logic [31:0] EXC_DIV  = 32'd5;

  localparam logic [4:0] REG_STATUS = 5'd30;
  localparam logic [4:0] REG_LINK   = 5'd31;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB
  } state_t;

endpackage

// File: rtl/processor_alu.sv
// Combinational integer ALU. ovf flags signed overflow on add/sub/mul
// and a zero divisor on div; the other operations never raise it.
module processor_alu
  import processor_pkg::*;
(
  input  logic signed [31:0] a,
  input  logic signed [31:0] b,
  input  logic        [4:0]  shamt,
  input  logic        [4:0]  aluop,
  output logic signed [31:0] result,
  output logic               ovf
);

  logic signed [63:0] product;

  always_comb begin
    result  = 32'sd0;
    ovf     = 1'b0;
    product = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    case (aluop)
      ALU_ADD: begin
        result = a + b;
        ovf    = (a[31] == b[31]) && (result[31] != a[31]);
      end
      ALU_SUB: begin
        result = a - b;
        ovf    = (a[31] != b[31]) && (result[31] != a[31]);
      end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_SLL: result = a <<< shamt;
      ALU_SRA: result = a >>> shamt;
      ALU_MUL: begin
        result = product[31:0];
        ovf    = (product[63:31] != {33{product[31]}});
      end
      ALU_DIV: begin
        // INT_MIN / -1 is pinned to INT_MIN so the divider never sees it.
        if (b == 32'sd0) begin
          ovf = 1'b1;
        end else if (a == 32'sh8000_0000 && b == -32'sd1) begin
          result = a;
        end else begin
          result = a / b;
        end
      end
      default: result = 32'sd0;
    endcase
  end

endmodule

// File: rtl/processor_core.sv
// Five-cycle, non-pipelined 32-bit CPU: FETCH, DECODE, EXEC, MEM, WB.
// Instruction/data memories are synchronous; the regfile reads combinationally.
module processor_core
  import processor_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] address_imem,
  input  logic [31:0] q_imem,
  output logic        ctrl_writeEnable,
  output logic [4:0]  ctrl_writeReg,
  output logic [4:0]  ctrl_readRegA,
  output logic [4:0]  ctrl_readRegB,
  output logic [31:0] data_writeReg,
  input  logic [31:0] data_readRegA,
  input  logic [31:0] data_readRegB,
  output logic        wren,
  output logic [31:0] address_dmem,
  output logic [31:0] data,
  input  logic [31:0] q_dmem
);

  state_t      state, state_nxt;
  logic [31:0] pc, ir;
  logic        wr_en_q;
  logic [31:0] result_q, next_pc_q;
  logic [4:0]  wr_reg_q;

  logic [4:0]  op, rd, rs, rt, shamt, aluop;
  logic [31:0] imm_sext, target;

  logic signed [31:0] alu_a, alu_b, alu_res;
  logic        [4:0]  alu_op;
  logic               alu_ovf;

  logic        exe_wr_en;
  logic [4:0]  exe_wr_reg;
  logic [31:0] exe_result, exe_next_pc;

  assign op       = ir[31:27];
  assign rd       = ir[26:22];
  assign rs       = ir[21:17];
  assign rt       = ir[16:12];
  assign shamt    = ir[11:7];
  assign aluop    = ir[6:2];
  assign imm_sext = {{15{ir[16]}}, ir[16:0]};
  assign target   = {5'd0, ir[26:0]};

  always_comb begin
    ctrl_readRegA = rs;
    ctrl_readRegB = rt;
    case (op)
      OP_SW:         ctrl_readRegB = rd;
      OP_BNE,
      OP_BLT: begin
        ctrl_readRegA = rd;
        ctrl_readRegB = rs;
      end
      OP_JR:         ctrl_readRegA = rd;
      OP_BEX:        ctrl_readRegA = REG_STATUS;
      default: ;
    endcase
  end

  assign alu_a  = data_readRegA;
  assign alu_b  = (op == OP_RTYPE) ? data_readRegB : imm_sext;
  assign alu_op = (op == OP_RTYPE) ? aluop : ALU_ADD;

  processor_alu u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .shamt  (shamt),
    .aluop  (alu_op),
    .result (alu_res),
    .ovf    (alu_ovf)
  );

  // Writeback target/value and next PC, all resolved during EXEC.
  always_comb begin
    exe_wr_en   = 1'b0;
    exe_wr_reg  = rd;
    exe_result  = alu_res;
    exe_next_pc = pc + 32'd1;
    case (op)
      OP_RTYPE: begin
        exe_wr_en = (aluop <= ALU_DIV);
        if (alu_ovf) begin
          exe_wr_reg = REG_STATUS;
          case (aluop)
            ALU_ADD: exe_result = EXC_ADD;
            ALU_SUB: exe_result = EXC_SUB;
            ALU_MUL: exe_result = EXC_MUL;
            default: exe_result = EXC_DIV;
          endcase
        end
      end
      OP_ADDI: begin
        exe_wr_en = 1'b1;
        if (alu_ovf) begin
          exe_wr_reg = REG_STATUS;
          exe_result = EXC_ADDI;
        end
      end
      OP_LW:   exe_wr_en = 1'b1;
      OP_BNE:  if (data_readRegA != data_readRegB) exe_next_pc = pc + 32'd1 + imm_sext;
      OP_BLT:  if ($signed(data_readRegA) < $signed(data_readRegB))
                 exe_next_pc = pc + 32'd1 + imm_sext;
      OP_J:    exe_next_pc = target;
      OP_JAL: begin
        exe_wr_en   = 1'b1;
        exe_wr_reg  = REG_LINK;
        exe_result  = pc + 32'd1;
        exe_next_pc = target;
      end
      OP_JR:   exe_next_pc = data_readRegA;
      OP_BEX:  if (data_readRegA != 32'd0) exe_next_pc = target;
      OP_SETX: begin
        exe_wr_en  = 1'b1;
        exe_wr_reg = REG_STATUS;
        exe_result = target;
      end
      default: ;
    endcase
    // r0 is hardwired, so its write strobe is simply never raised.
    if (exe_wr_reg == 5'd0) exe_wr_en = 1'b0;
  end

  always_comb begin
    state_nxt = S_FETCH;
    case (state)
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: state_nxt = S_EXEC;
      S_EXEC:   state_nxt = S_MEM;
      S_MEM:    state_nxt = S_WB;
      S_WB:     state_nxt = S_FETCH;
      default:  state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= S_FETCH;
      pc      <= RESET_PC;
      ir      <= 32'd0;
      wr_en_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_DECODE) ir <= q_imem;
      if (state == S_EXEC) wr_en_q <= exe_wr_en;
      if (state == S_WB) pc <= next_pc_q;
    end
  end

  always_ff @(posedge clock) begin
    if (state == S_EXEC) begin
      result_q  <= exe_result;
      wr_reg_q  <= exe_wr_reg;
      next_pc_q <= exe_next_pc;
    end
    if (state == S_MEM && op == OP_LW) result_q <= q_dmem;
  end

  assign address_imem     = pc;
  assign address_dmem     = alu_res;
  assign data             = data_readRegB;
  assign wren             = (state == S_EXEC) && (op == OP_SW);
  assign ctrl_writeEnable = (state == S_WB) && wr_en_q;
  assign ctrl_writeReg    = wr_reg_q;
  assign data_writeReg    = result_q;

endmodule

// File: tb/tb_processor_core.sv
// Directed bench for processor_core with behavioural ROM, RAM and regfile models.
module tb_processor_core;

  localparam logic [4:0] T_RTYPE = 5'b00000, T_J = 5'b00001, T_BNE = 5'b00010,
                         T_JAL = 5'b00011, T_JR = 5'b00100, T_ADDI = 5'b00101,
                         T_BLT = 5'b00110, T_SW = 5'b00111, T_LW = 5'b01000,
                         T_SETX = 5'b10101, T_BEX = 5'b10110;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        clr   = 1'b0;
  logic [31:0] address_imem, q_imem;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg, ctrl_readRegA, ctrl_readRegB;
  logic [31:0] data_writeReg, data_readRegA, data_readRegB;
  logic        wren;
  logic [31:0] address_dmem, data, q_dmem;

  logic [31:0] rom [4096];
  logic [31:0] ram [4096];
  logic [31:0] rf  [32];

  int n_checks = 0;
  int n_fails  = 0;
  int cyc, we_cnt, we_bad, wren_cnt, wren_bad;

  processor_core dut (
    .clock            (clock),
    .reset            (reset),
    .address_imem     (address_imem),
    .q_imem           (q_imem),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .ctrl_readRegA    (ctrl_readRegA),
    .ctrl_readRegB    (ctrl_readRegB),
    .data_writeReg    (data_writeReg),
    .data_readRegA    (data_readRegA),
    .data_readRegB    (data_readRegB),
    .wren             (wren),
    .address_dmem     (address_dmem),
    .data             (data),
    .q_dmem           (q_dmem)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    q_imem <= rom[address_imem[11:0]];
    q_dmem <= ram[address_dmem[11:0]];
    if (clr) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
      for (int i = 0; i < 4096; i++) ram[i] <= 32'd0;
    end else begin
      if (wren) ram[address_dmem[11:0]] <= data;
      if (ctrl_writeEnable && ctrl_writeReg != 5'd0) rf[ctrl_writeReg] <= data_writeReg;
    end
  end

  assign data_readRegA = (ctrl_readRegA == 5'd0) ? 32'd0 : rf[ctrl_readRegA];
  assign data_readRegB = (ctrl_readRegB == 5'd0) ? 32'd0 : rf[ctrl_readRegB];

  always @(posedge clock or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // Strobe monitor: writes only in WB (period 4 of 5), RAM writes only in EXEC (period 2).
  always @(negedge clock) begin
    if (reset) begin
      we_cnt = 0; we_bad = 0; wren_cnt = 0; wren_bad = 0;
    end else begin
      if (ctrl_writeEnable) begin
        we_cnt++;
        if (cyc % 5 != 4) we_bad++;
      end
      if (wren) begin
        wren_cnt++;
        if (cyc % 5 != 2) wren_bad++;
      end
    end
  end

  function automatic logic [31:0] r_type(input logic [4:0] rd, rs, rt, sh, aop);
    return {T_RTYPE, rd, rs, rt, sh, aop, 2'b00};
  endfunction

  function automatic logic [31:0] i_type(input logic [4:0] op, rd, rs, input int imm);
    logic [31:0] t;
    t = imm;
    return {op, rd, rs, t[16:0]};
  endfunction

  function automatic logic [31:0] j_type(input logic [4:0] op, input int tgt);
    logic [31:0] t;
    t = tgt;
    return {op, t[26:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rom_clear();
    for (int i = 0; i < 4096; i++) rom[i] = 32'd0;
  endtask

  // Leaves the core in period 0 (FETCH of the first instruction), 2 time units after an edge.
  task automatic start();
    reset = 1'b1;
    clr   = 1'b1;
    @(posedge clock);
    @(posedge clock);
    #2;
    clr   = 1'b0;
    reset = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  initial begin
    rom_clear();
    #3;
    check("reset_pc", address_imem, 32'd0);
    check("reset_wren", {31'd0, wren}, 32'd0);
    check("reset_we", {31'd0, ctrl_writeEnable}, 32'd0);

    // 1: all-nop ROM, PC steps once per 5 cycles, nothing written.
    start();
    check("t1_pc0", address_imem, 32'd0);
    run(5);
    check("t1_pc1", address_imem, 32'd1);
    run(15);
    check("t1_pc4", address_imem, 32'd4);
    check("t1_we_cnt", we_cnt, 32'd0);
    check("t1_wren_cnt", wren_cnt, 32'd0);

    // 2: addi/add/sub.
    rom_clear();
    rom[0] = i_type(T_ADDI, 5'd1, 5'd0, 5);
    rom[1] = i_type(T_ADDI, 5'd2, 5'd0, 7);
    rom[2] = r_type(5'd3, 5'd1, 5'd2, 5'd0, 5'd0);
    rom[3] = r_type(5'd4, 5'd1, 5'd2, 5'd0, 5'd1);
    start();
    run(4);
    check("t2_wb_we", {31'd0, ctrl_writeEnable}, 32'd1);
    check("t2_wb_reg", {27'd0, ctrl_writeReg}, 32'd1);
    check("t2_wb_data", data_writeReg, 32'd5);
    run(1);
    check("t2_after_wb_we", {31'd0, ctrl_writeEnable}, 32'd0);
    run(15);
    check("t2_r1", rf[1], 32'd5);
    check("t2_r2", rf[2], 32'd7);
    check("t2_r3", rf[3], 32'd12);
    check("t2_r4", rf[4], 32'hFFFF_FFFE);
    check("t2_we_cnt", we_cnt, 32'd4);
    check("t2_we_phase", we_bad, 32'd0);

    // 3: sub overflow routes status 3 to r30, leaves rd untouched.
    rom_clear();
    rom[0] = i_type(T_ADDI, 5'd1, 5'd0, 1);
    rom[1] = r_type(5'd1, 5'd1, 5'd0, 5'd31, 5'd4);
    rom[2] = i_type(T_ADDI, 5'd2, 5'd0, 9);
    rom[3] = i_type(T_ADDI, 5'd5, 5'd0, 1);
    rom[4] = r_type(5'd2, 5'd1, 5'd5, 5'd0, 5'd1);
    start();
    run(25);
    check("t3_r1", rf[1], 32'h8000_0000);
    check("t3_r30", rf[30], 32'd3);
    check("t3_r2", rf[2], 32'd9);

    // 4: store then load.
    rom_clear();
    rom[0] = i_type(T_ADDI, 5'd1, 5'd0, 42);
    rom[1] = i_type(T_SW, 5'd1, 5'd0, 3);
    rom[2] = i_type(T_LW, 5'd2, 5'd0, 3);
    start();
    run(7);
    check("t4_sw_wren", {31'd0, wren}, 32'd1);
    check("t4_sw_addr", address_dmem, 32'd3);
    check("t4_sw_data", data, 32'd42);
    run(8);
    check("t4_ram3", ram[3], 32'd42);
    check("t4_r2", rf[2], 32'd42);
    check("t4_wren_cnt", wren_cnt, 32'd1);
    check("t4_wren_phase", wren_bad, 32'd0);

    // 5: branches, jal/jr.
    rom_clear();
    rom[0]  = i_type(T_ADDI, 5'd1, 5'd0, 3);
    rom[1]  = i_type(T_ADDI, 5'd2, 5'd0, -4);
    rom[2]  = i_type(T_BNE, 5'd1, 5'd0, 1);
    rom[3]  = i_type(T_ADDI, 5'd10, 5'd0, 1);
    rom[4]  = i_type(T_BNE, 5'd0, 5'd0, 1);
    rom[5]  = i_type(T_ADDI, 5'd11, 5'd0, 2);
    rom[6]  = i_type(T_BLT, 5'd2, 5'd1, 1);
    rom[7]  = i_type(T_ADDI, 5'd12, 5'd0, 3);
    rom[8]  = i_type(T_BLT, 5'd1, 5'd2, 1);
    rom[9]  = i_type(T_ADDI, 5'd13, 5'd0, 4);
    rom[10] = j_type(T_JAL, 20);
    rom[11] = i_type(T_ADDI, 5'd14, 5'd0, 5);
    rom[12] = j_type(T_J, 12);
    rom[20] = i_type(T_ADDI, 5'd15, 5'd0, 6);
    rom[21] = i_type(T_JR, 5'd31, 5'd0, 0);
    rom[22] = i_type(T_ADDI, 5'd16, 5'd0, 7);
    start();
    run(60);
    check("t5_pc", address_imem, 32'd12);
    check("t5_r10_skipped", rf[10], 32'd0);
    check("t5_r11", rf[11], 32'd2);
    check("t5_r12_skipped", rf[12], 32'd0);
    check("t5_r13", rf[13], 32'd4);
    check("t5_r31", rf[31], 32'd11);
    check("t5_r15", rf[15], 32'd6);
    check("t5_r14", rf[14], 32'd5);
    check("t5_r16_skipped", rf[16], 32'd0);
    check("t5_we_cnt", we_cnt, 32'd7);

    // 6: div by zero, bex taken, setx 0, bex not taken.
    rom_clear();
    rom[0]  = i_type(T_ADDI, 5'd1, 5'd0, 7);
    rom[1]  = r_type(5'd3, 5'd1, 5'd0, 5'd0, 5'd7);
    rom[2]  = j_type(T_BEX, 10);
    rom[3]  = i_type(T_ADDI, 5'd20, 5'd0, 1);
    rom[10] = j_type(T_SETX, 0);
    rom[11] = j_type(T_BEX, 20);
    rom[12] = i_type(T_ADDI, 5'd21, 5'd0, 9);
    rom[13] = j_type(T_J, 13);
    start();
    run(10);
    check("t6_r30_div", rf[30], 32'd5);
    check("t6_r3", rf[3], 32'd0);
    run(20);
    check("t6_pc", address_imem, 32'd13);
    check("t6_r30_setx", rf[30], 32'd0);
    check("t6_r20_skipped", rf[20], 32'd0);
    check("t6_r21", rf[21], 32'd9);

    // 7: reset asserted while sw is in EXEC aborts the store.
    rom_clear();
    rom[0] = i_type(T_ADDI, 5'd1, 5'd0, 42);
    rom[1] = i_type(T_SW, 5'd1, 5'd0, 3);
    start();
    run(7);
    check("t7_pre_wren", {31'd0, wren}, 32'd1);
    reset = 1'b1;
    #1;
    check("t7_async_wren", {31'd0, wren}, 32'd0);
    check("t7_async_pc", address_imem, 32'd0);
    check("t7_async_we", {31'd0, ctrl_writeEnable}, 32'd0);
    run(2);
    check("t7_ram3", ram[3], 32'd0);
    check("t7_r1", rf[1], 32'd42);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
